spi_controller: RTL and testbench



---
 rtl/spi_controller.sv | 200 ++++++++++++++++++++
 tb/tb_spi_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 master that sends 16-bit register frames.
// Frame layout, MSB first: {rw, addr[6:0], data[7:0]}.
// Optional read-back: define SPI_CTRL_CIPO_EN to add the CIPO input and the
// rsp_valid/rsp_data response port. When it is not defined, read frames are
// still shifted out, but nothing is captured from the peripheral.
module spi_controller #(
    parameter int SCLK_HALF = 4,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int CS_GAP    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       busy,
    output logic       nCS,
    output logic       SCLK,
`ifdef SPI_CTRL_CIPO_EN
    input  logic       CIPO,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
`endif
    output logic       COPI
);

    // One shared down-counter serves every timed phase, so it is sized for the
    // longest of them.
    localparam int MAX_A = (SCLK_HALF > CS_SETUP) ? SCLK_HALF : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] HALF_LD  = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [3:0]      bit_reg;
    logic [15:0]     shift_reg;
    logic            ncs_reg;
    logic            sclk_reg;
    logic            ready_reg;
    logic            done_reg;
    logic            busy_reg;
    logic            finish_next;
`ifdef SPI_CTRL_CIPO_EN
    logic            rw_reg;
    logic [7:0]      rx_reg;
    logic            rsp_valid_reg;
    logic [7:0]      rsp_data_reg;
`endif

    // done must be high during the last GAP cycle, so it is raised on the
    // edge that enters that cycle (directly from HOLD when the gap is 1 cycle).
    always_comb begin
        finish_next = 1'b0;
        if (state_reg == HOLD && cnt_reg == '0 && CS_GAP == 1)
            finish_next = 1'b1;
        if (state_reg == GAP && cnt_reg == CW'(1))
            finish_next = 1'b1;
    end

    // Frame sequencer: all pin and handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_reg       <= 4'd0;
            shift_reg     <= 16'd0;
            ncs_reg       <= 1'b1;
            sclk_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef SPI_CTRL_CIPO_EN
            rw_reg        <= 1'b0;
            rx_reg        <= 8'd0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 8'd0;
`endif
        end else begin
            done_reg <= 1'b0;
`ifdef SPI_CTRL_CIPO_EN
            rsp_valid_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    ncs_reg  <= 1'b1;
                    sclk_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    if (req_valid && ready_reg) begin
                        state_reg <= SETUP;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        ncs_reg   <= 1'b0;
                        shift_reg <= {req_rw, req_addr, req_data};
                        cnt_reg   <= SETUP_LD;
                        bit_reg   <= 4'd15;
`ifdef SPI_CTRL_CIPO_EN
                        rw_reg    <= req_rw;
`endif
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= SHIFT;
                        cnt_reg   <= HALF_LD;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (!sclk_reg) begin
                        sclk_reg <= 1'b1;
                        cnt_reg  <= HALF_LD;
                    end else begin
                        // End of a high phase: SCLK falls and COPI moves on
                        // together, so data is stable around every rise.
                        sclk_reg <= 1'b0;
`ifdef SPI_CTRL_CIPO_EN
                        if (bit_reg < 4'd8)
                            rx_reg <= {rx_reg[6:0], CIPO};
`endif
                        if (bit_reg == 4'd0) begin
                            state_reg <= HOLD;
                            cnt_reg   <= HOLD_LD;
                        end else begin
                            bit_reg   <= bit_reg - 1'b1;
                            shift_reg <= {shift_reg[14:0], 1'b0};
                            cnt_reg   <= HALF_LD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= GAP;
                        ncs_reg   <= 1'b1;
                        shift_reg <= 16'd0;
                        cnt_reg   <= GAP_LD;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (finish_next) begin
                done_reg <= 1'b1;
`ifdef SPI_CTRL_CIPO_EN
                if (!rw_reg) begin
                    rsp_valid_reg <= 1'b1;
                    rsp_data_reg  <= rx_reg;
                end
`endif
            end
        end
    end

    assign req_ready = ready_reg;
    assign done      = done_reg;
    assign busy      = busy_reg;
    assign nCS       = ncs_reg;
    assign SCLK      = sclk_reg;
    assign COPI      = shift_reg[15];
`ifdef SPI_CTRL_CIPO_EN
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a default-parameter instance (index 0)
// and a minimum-timing instance (index 1), plus a small peripheral model that
// decodes frames from the pins and keeps a register bank.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid_v = 2'b00;
    logic [1:0] req_rw_v    = 2'b00;
    logic [6:0] req_addr_v [2];
    logic [7:0] req_data_v [2];
    logic [1:0] ready_v, done_v, busy_v, ncs_v, sclk_v, copi_v;
`ifdef SPI_CTRL_CIPO_EN
    logic       cipo_m = 1'b0;
    logic [7:0] cipo_byte = 8'h00;
    logic       rsp_valid0, rsp_valid1;
    logic [7:0] rsp_data0, rsp_data1;
    int         rsp_with_done = 0;
    int         rsp_stray = 0;
`endif

    int total = 0;
    int bad   = 0;

    // monitor state per instance
    logic        pncs [2];
    logic        psclk [2];
    logic [15:0] word_m [2];
    int          low_len [2];
    int          high_len [2];
    int          rises [2];
    int          last_gap [2];
    int          last_len [2];
    int          last_rises [2];
    logic [15:0] last_word [2];
    int          done_cnt [2];
    int          ready_bad [2];
    logic [15:0] words_q [$];
    logic [7:0]  bank [128];

    always #5 clk = ~clk;

    spi_controller dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid_v[0]),
        .req_ready (ready_v[0]),
        .req_rw    (req_rw_v[0]),
        .req_addr  (req_addr_v[0]),
        .req_data  (req_data_v[0]),
        .done      (done_v[0]),
        .busy      (busy_v[0]),
        .nCS       (ncs_v[0]),
        .SCLK      (sclk_v[0]),
`ifdef SPI_CTRL_CIPO_EN
        .CIPO      (cipo_m),
        .rsp_valid (rsp_valid0),
        .rsp_data  (rsp_data0),
`endif
        .COPI      (copi_v[0])
    );

    spi_controller #(
        .SCLK_HALF (2),
        .CS_SETUP  (1),
        .CS_HOLD   (1),
        .CS_GAP    (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid_v[1]),
        .req_ready (ready_v[1]),
        .req_rw    (req_rw_v[1]),
        .req_addr  (req_addr_v[1]),
        .req_data  (req_data_v[1]),
        .done      (done_v[1]),
        .busy      (busy_v[1]),
        .nCS       (ncs_v[1]),
        .SCLK      (sclk_v[1]),
`ifdef SPI_CTRL_CIPO_EN
        .CIPO      (1'b0),
        .rsp_valid (rsp_valid1),
        .rsp_data  (rsp_data1),
`endif
        .COPI      (copi_v[1])
    );

    // Pin monitor and peripheral model, sampled on the falling clk edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ncs_v[i] === 1'b0 && pncs[i] === 1'b1) begin
                low_len[i]  = 0;
                rises[i]    = 0;
                word_m[i]   = 16'h0;
                last_gap[i] = high_len[i];
            end
            if (ncs_v[i] === 1'b0) begin
                low_len[i]++;
                if (sclk_v[i] === 1'b1 && psclk[i] === 1'b0) begin
                    word_m[i] = {word_m[i][14:0], copi_v[i]};
                    rises[i]++;
                end
            end
            if (ncs_v[i] === 1'b1 && pncs[i] === 1'b0) begin
                last_word[i]  = word_m[i];
                last_len[i]   = low_len[i];
                last_rises[i] = rises[i];
                high_len[i]   = 0;
                if (i == 0) begin
                    words_q.push_back(word_m[i]);
                    if (rises[i] == 16 && word_m[i][15])
                        bank[word_m[i][14:8]] = word_m[i][7:0];
                end
                $display("frame dut%0d word=%h ncs_low=%0d rises=%0d", i, word_m[i], low_len[i], rises[i]);
            end
            if (ncs_v[i] === 1'b1)
                high_len[i]++;
            if (done_v[i] === 1'b1)
                done_cnt[i]++;
            if (busy_v[i] === 1'b1 && ready_v[i] === 1'b1)
                ready_bad[i]++;
            pncs[i]  = ncs_v[i];
            psclk[i] = sclk_v[i];
        end
`ifdef SPI_CTRL_CIPO_EN
        if (ncs_v[0] === 1'b0 && rises[0] >= 9 && rises[0] <= 16)
            cipo_m = cipo_byte[16 - rises[0]];
        else
            cipo_m = 1'b0;
        if (rsp_valid0 === 1'b1 && done_v[0] === 1'b1)
            rsp_with_done++;
        if (rsp_valid0 === 1'b1 && done_v[0] !== 1'b1)
            rsp_stray++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (ready_v[d] !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n == 2000)
            chk("ready_timeout", 32'(ready_v[d]), 32'd1);
    endtask

    task automatic wait_done(input int d, input int target);
        for (int i = 0; i < 3000 && done_cnt[d] < target; i++)
            tick();
        chk("done_seen", done_cnt[d], target);
        wait_ready(d);
    endtask

    // Present one request and return right after it has been accepted.
    task automatic send(input int d, input logic rw, input logic [6:0] a, input logic [7:0] dat);
        req_rw_v[d]    = rw;
        req_addr_v[d]  = a;
        req_data_v[d]  = dat;
        req_valid_v[d] = 1'b1;
        wait_ready(d);
        tick();
        req_valid_v[d] = 1'b0;
        $display("req dut%0d rw=%0d addr=%h data=%h accepted", d, rw, a, dat);
    endtask

    initial begin
        int base;
        int nq;
        for (int i = 0; i < 2; i++) begin
            pncs[i] = 1'b1; psclk[i] = 1'b0; word_m[i] = 16'h0;
            low_len[i] = 0; high_len[i] = 0; rises[i] = 0; last_gap[i] = 0;
            last_len[i] = 0; last_rises[i] = 0; last_word[i] = 16'h0;
            done_cnt[i] = 0; ready_bad[i] = 0;
            req_addr_v[i] = 7'h0; req_data_v[i] = 8'h0;
        end
        for (int i = 0; i < 128; i++) bank[i] = 8'h00;

        // reset state
        repeat (3) tick();
        chk("rst_ncs", 32'(ncs_v[0]), 32'd1);
        chk("rst_sclk", 32'(sclk_v[0]), 32'd0);
        chk("rst_copi", 32'(copi_v[0]), 32'd0);
        chk("rst_ready", 32'(ready_v[0]), 32'd0);
        chk("rst_done_busy", 32'({done_v[0], busy_v[0]}), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_ready", 32'(ready_v[0]), 32'd1);

        // single write frame, default timing
        base = done_cnt[0];
        send(0, 1'b1, 7'h04, 8'hA5);
        chk("accept_busy_ready", 32'({busy_v[0], ready_v[0]}), 32'b10);
        wait_done(0, base + 1);
        chk("w1_word", 32'(last_word[0]), 32'h84A5);
        chk("w1_ncs_low", last_len[0], 136);
        chk("w1_rises", last_rises[0], 16);
        chk("w1_done_pulses", done_cnt[0] - base, 1);
        chk("w1_ready_while_busy", ready_bad[0], 0);

        // writes land in the peripheral register bank
        send(0, 1'b1, 7'h00, 8'h3C);
        wait_done(0, base + 2);
        send(0, 1'b1, 7'h01, 8'hF0);
        wait_done(0, base + 3);
        chk("bank_en_out_7_0", 32'(bank[0]), 32'h3C);
        chk("bank_en_out_15_8", 32'(bank[1]), 32'hF0);

        // back-to-back with req_valid held high
        base = done_cnt[0];
        nq = words_q.size();
        req_rw_v[0] = 1'b1; req_addr_v[0] = 7'h10; req_data_v[0] = 8'h11;
        req_valid_v[0] = 1'b1;
        wait_ready(0);
        tick();
        req_addr_v[0] = 7'h7F; req_data_v[0] = 8'hEE;
        wait_done(0, base + 1);
        tick();
        req_valid_v[0] = 1'b0;
        wait_done(0, base + 2);
        chk("b2b_count", words_q.size() - nq, 2);
        if (words_q.size() - nq == 2) begin
            chk("b2b_word_a", 32'(words_q[nq]), 32'h9011);
            chk("b2b_word_b", 32'(words_q[nq + 1]), 32'hFFEE);
        end
        chk("b2b_gap_ok", 32'(last_gap[0] >= 4), 32'd1);
        chk("b2b_done_pulses", done_cnt[0] - base, 2);

        // reset during bit 9 of the shift
        send(0, 1'b1, 7'h2A, 8'h77);
        for (int i = 0; i < 2000 && rises[0] < 7; i++)
            tick();
        chk("abort_reached_bit9", rises[0], 7);
        base = done_cnt[0];
        rst = 1'b1;
        tick();
        chk("abort_ncs", 32'(ncs_v[0]), 32'd1);
        chk("abort_sclk", 32'(sclk_v[0]), 32'd0);
        rst = 1'b0;
        repeat (300) tick();
        chk("abort_no_done", done_cnt[0] - base, 0);
        send(0, 1'b1, 7'h01, 8'h55);
        wait_done(0, base + 1);
        chk("after_abort_word", 32'(last_word[0]), 32'h8155);
        chk("after_abort_rises", last_rises[0], 16);

        // minimum timing instance
        send(1, 1'b1, 7'h33, 8'h96);
        wait_done(1, 1);
        chk("fast_word", 32'(last_word[1]), 32'hB396);
        chk("fast_ncs_low", last_len[1], 66);
        chk("fast_rises", last_rises[1], 16);

`ifdef SPI_CTRL_CIPO_EN
        // read-back through CIPO
        chk("no_rsp_on_writes", rsp_with_done + rsp_stray, 0);
        cipo_byte = 8'hC3;
        base = done_cnt[0];
        send(0, 1'b0, 7'h02, 8'h00);
        wait_done(0, base + 1);
        chk("rd_word", 32'(last_word[0]), 32'h0200);
        chk("rd_rsp_with_done", rsp_with_done, 1);
        chk("rd_rsp_stray", rsp_stray, 0);
        chk("rd_rsp_data", 32'(rsp_data0), 32'hC3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
